// File: rtl/store_trace_pkg.sv
// Shared types for the store trace monitor: run-state encoding and event sizing.
package store_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int EVT_W      = DEF_ADDR_W + DEF_DATA_W;

endpackage

// File: rtl/store_evt_fifo.sv
// Registered event FIFO with extra-MSB pointers; head is presented combinationally.
module store_evt_fifo
    import store_trace_pkg::*;
#(
    parameter int WIDTH = EVT_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign valid   = (wptr_q != rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem_q[rptr_q[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/store_trace_monitor.sv
// Watches the cpu data-memory write port, queues store events and decides the run outcome.
module store_trace_monitor
    import store_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 50,
    parameter int TOHOST_ADDR = 100,
    parameter int PASS_VALUE  = 25,
    localparam int CYC_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [ADDR_W-1:0] evt_addr,
    output logic [DATA_W-1:0] evt_data,
    output logic [CNT_W-1:0]  store_count,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              overflow
);

    localparam int EW = ADDR_W + DATA_W;

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, fifo_full, tohost;
    logic [EW-1:0]     fifo_dout;

    assign pop    = evt_valid && evt_ready;
    assign tohost = mem_write && (mem_addr == ADDR_W'(TOHOST_ADDR));

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        if (state_q == ST_RUN) begin
            cycle_d = cycle_q + CYC_W'(1);
            if (mem_write) begin
                push = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (fifo_full && !pop) ovf_d = 1'b1;
            end
            // A tohost store outranks the timeout when both land on the same edge.
            if (tohost) begin
                state_d = (mem_wdata == DATA_W'(PASS_VALUE)) ? ST_PASS : ST_FAIL;
            end else if (cycle_q == CYC_W'(TIMEOUT_CYC - 1)) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cycle_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    store_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({mem_addr, mem_wdata}),
        .pop   (evt_ready),
        .dout  (fifo_dout),
        .valid (evt_valid),
        .full  (fifo_full)
    );

    assign {evt_addr, evt_data} = fifo_dout;
    assign store_count = cnt_q;
    assign cycle_count = cycle_q;
    assign overflow    = ovf_q;
    assign pass        = (state_q == ST_PASS);
    assign fail        = (state_q == ST_FAIL);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign done        = pass | fail | timeout;

endmodule

// File: tb/tb_store_trace_monitor.sv
// Scenario bench for store_trace_monitor: expected events are queued as stores are driven.
module tb_store_trace_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = AW + DW;

  logic          clk;
  logic          rst;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          evt_ready;
  logic          evt_valid;
  logic [AW-1:0] evt_addr;
  logic [DW-1:0] evt_data;
  logic [15:0]   store_count;
  logic [5:0]    cycle_count;
  logic          done, pass, fail, timeout, overflow;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  store_trace_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_addr    (evt_addr),
    .evt_data    (evt_data),
    .store_count (store_count),
    .cycle_count (cycle_count),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .overflow    (overflow)
  );

  // clock / reset: rising edges at 10, 20, 30 ns ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_write = 1'b0;
    evt_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
    mem_write = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    if (accept) exp_q.push_back({a, d});
    tick();
    mem_write = 1'b0;
  endtask

  // scoreboard: pop the FIFO and compare every head against the expected queue
  task automatic drain(input string name);
    int guard;
    logic [EW-1:0] exp;
    guard = 0;
    evt_ready = 1'b1;
    while ((evt_valid || exp_q.size() != 0) && guard < 20) begin
      if (evt_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra_event: got %h, expected none", name, {evt_addr, evt_data});
        end else begin
          exp = exp_q.pop_front();
          if ({evt_addr, evt_data} !== exp) begin
            n_fail++;
            $display("FAIL %s_event: got %h, expected %h", name, {evt_addr, evt_data}, exp);
          end
        end
      end
      tick();
      guard++;
    end
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain_end: evt_valid=%b left=%0d, expected 0 and 0", name, evt_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_timeout();
    rst = 1'b1;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    evt_ready = 1'b0;
    #12;
    n_checks++;
    if ({evt_valid, done, pass, fail, timeout, overflow} !== 6'b0 || store_count !== 16'd0 || cycle_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b done=%b p=%b f=%b t=%b ovf=%b cnt=%0d cyc=%0d, expected all 0",
               evt_valid, done, pass, fail, timeout, overflow, store_count, cycle_count);
    end
    #13;
    rst = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    n_checks++;
    if (timeout !== 1'b0 || cycle_count !== 6'd49) begin
      n_fail++;
      $display("FAIL pre_timeout: timeout=%b cyc=%0d, expected 0 and 49", timeout, cycle_count);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b1 || done !== 1'b1 || cycle_count !== 6'd50) begin
      n_fail++;
      $display("FAIL timeout_edge: timeout=%b done=%b cyc=%0d, expected 1 1 50", timeout, done, cycle_count);
    end
    n_checks++;
    if (pass !== 1'b0 || fail !== 1'b0 || store_count !== 16'd0) begin
      n_fail++;
      $display("FAIL timeout_flags: pass=%b fail=%b cnt=%0d, expected 0 0 0", pass, fail, store_count);
    end
    drive_store(32'd100, 32'd25, 1'b0);
    n_checks++;
    if (pass !== 1'b0 || timeout !== 1'b1 || store_count !== 16'd0 || cycle_count !== 6'd50 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_frozen: pass=%b timeout=%b cnt=%0d cyc=%0d valid=%b, expected 0 1 0 50 0",
               pass, timeout, store_count, cycle_count, evt_valid);
    end
  endtask

  task automatic test_pass();
    do_reset();
    drive_store(32'd96, 32'd7, 1'b1);
    n_checks++;
    if (pass !== 1'b0 || done !== 1'b0 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_pre: pass=%b done=%b valid=%b, expected 0 0 1", pass, done, evt_valid);
    end
    drive_store(32'd100, 32'd25, 1'b1);
    n_checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || done !== 1'b1 || store_count !== 16'd2) begin
      n_fail++;
      $display("FAIL pass_state: pass=%b fail=%b done=%b cnt=%0d, expected 1 0 1 2", pass, fail, done, store_count);
    end
    drive_store(32'd200, 32'd1, 1'b0);
    n_checks++;
    if (store_count !== 16'd2) begin
      n_fail++;
      $display("FAIL pass_ignore: cnt=%0d, expected 2", store_count);
    end
    drain("pass");
  endtask

  task automatic test_fail();
    do_reset();
    drive_store(32'd100, 32'd24, 1'b1);
    n_checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || done !== 1'b1 || store_count !== 16'd1) begin
      n_fail++;
      $display("FAIL fail_state: fail=%b pass=%b done=%b cnt=%0d, expected 1 0 1 1", fail, pass, done, store_count);
    end
    drive_store(32'd5, 32'd5, 1'b0);
    drive_store(32'd100, 32'd25, 1'b0);
    n_checks++;
    if (store_count !== 16'd1 || pass !== 1'b0 || fail !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_frozen: cnt=%0d pass=%b fail=%b, expected 1 0 1", store_count, pass, fail);
    end
    drain("fail");
  endtask

  task automatic test_overflow();
    logic [EW-1:0] exp;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      drive_store(32'h200 + 32'(i * 4), d, i < 8);
    end
    n_checks++;
    if (store_count !== 16'd10 || overflow !== 1'b1 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state: cnt=%0d ovf=%b valid=%b, expected 10 1 1", store_count, overflow, evt_valid);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({evt_addr, evt_data} !== exp) begin
      n_fail++;
      $display("FAIL full_head: got %h, expected %h", {evt_addr, evt_data}, exp);
    end
    d = 32'($urandom_range(0, 1000));
    evt_ready = 1'b1;
    drive_store(32'h300, d, 1'b1);
    evt_ready = 1'b0;
    n_checks++;
    if (store_count !== 16'd11 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop: cnt=%0d valid=%b, expected 11 1", store_count, evt_valid);
    end
    drain("overflow");
  endtask

  task automatic test_tohost_vs_timeout();
    do_reset();
    repeat (49) tick();
    n_checks++;
    if (cycle_count !== 6'd49 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL race_pre: cyc=%0d timeout=%b, expected 49 0", cycle_count, timeout);
    end
    drive_store(32'd100, 32'd25, 1'b1);
    n_checks++;
    if (pass !== 1'b1 || timeout !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL race_result: pass=%b timeout=%b done=%b, expected 1 0 1", pass, timeout, done);
    end
    drain("race");
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_store(32'h40 + 32'(i), 32'($urandom_range(1, 255)), i < 8);
    end
    n_checks++;
    if (overflow !== 1'b1 || evt_valid !== 1'b1 || store_count !== 16'd9) begin
      n_fail++;
      $display("FAIL midrst_pre: ovf=%b valid=%b cnt=%0d, expected 1 1 9", overflow, evt_valid, store_count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || store_count !== 16'd0 || cycle_count !== 6'd0 || overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%b cnt=%0d cyc=%0d ovf=%b done=%b, expected all 0",
               evt_valid, store_count, cycle_count, overflow, done);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    drive_store(32'd60, 32'd3, 1'b1);
    n_checks++;
    if (store_count !== 16'd1 || evt_valid !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_resume: cnt=%0d valid=%b ovf=%b, expected 1 1 0", store_count, evt_valid, overflow);
    end
    drain("midrst");
  endtask

  initial begin
    test_reset_timeout();
    test_pass();
    test_fail();
    test_overflow();
    test_tohost_vs_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
